// File: rtl/lcd_8080_pkg.sv
// Shared types and register map for the 8080-style LCD bus controller.
package lcd_8080_pkg;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RST    = 2'd3;

  typedef struct packed {
    logic        dc;
    logic [15:0] data;
  } lcd_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH
  } lcd_state_e;

endpackage

// File: rtl/lcd_word_fifo.sv
// First-word-fall-through synchronous FIFO of LCD bus words; DEPTH must be a power of two.
module lcd_word_fifo
  import lcd_8080_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  lcd_word_t                wdata,
  input  logic                     pop,
  output lcd_word_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        do_push, do_pop;
  lcd_word_t   mem_q [DEPTH];

  assign level   = wptr_q - rptr_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, and a reset-free array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_8080_ctrl.sv
// Avalon-MM slave that queues LCD command/data words and replays them on an 8080 bus.
// Define LCD_HW_RESET_EN to add a software-controlled lcd_reset_n output at register 3.
module lcd_8080_ctrl
  import lcd_8080_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        lcd_wr_n,
  output logic        lcd_data_com_n,
  output logic [15:0] lcd_data
`ifdef LCD_HW_RESET_EN
  ,
  output logic        lcd_reset_n
`endif
);

  localparam int         LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH_CYC - 1);

  lcd_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_n_q, wr_n_d;
  lcd_word_t   word_q, word_d;
  logic [31:0] readdata_q, readdata_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  lcd_word_t     push_word, fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [7:0]    level8;
  logic          is_fifo_addr, run_en, load_next;
  logic [31:0]   status, rst_rd;
  logic          unused_wdata;

  assign unused_wdata = ^avs_writedata[31:16];

  assign is_fifo_addr    = (avs_address == ADDR_CMD) | (avs_address == ADDR_DATA);
  assign avs_waitrequest = avs_write & is_fifo_addr & fifo_full;
  assign fifo_push       = avs_write & is_fifo_addr & ~fifo_full;
  assign push_word.dc    = (avs_address == ADDR_DATA);
  assign push_word.data  = avs_writedata[15:0];

  lcd_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign level8 = {{(8 - LW){1'b0}}, fifo_level};
  assign status = {16'b0, level8, 6'b0, fifo_full, (state_q != IDLE) | ~fifo_empty};

`ifdef LCD_HW_RESET_EN
  logic lcd_rst_n_q, lcd_rst_n_d;

  always_comb begin
    lcd_rst_n_d = lcd_rst_n_q;
    if (avs_write && avs_address == ADDR_RST) lcd_rst_n_d = avs_writedata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) lcd_rst_n_q <= 1'b0;
    else       lcd_rst_n_q <= lcd_rst_n_d;
  end

  // Panel held in reset: words keep queueing but nothing is strobed out.
  assign run_en      = lcd_rst_n_q;
  assign rst_rd      = {31'b0, lcd_rst_n_q};
  assign lcd_reset_n = lcd_rst_n_q;
`else
  assign run_en = 1'b1;
  assign rst_rd = '0;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_n_d    = wr_n_q;
    word_d    = word_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
    case (state_q)
      IDLE:  load_next = ~fifo_empty & run_en;
      SETUP: begin
        state_d = LOW;
        wr_n_d  = 1'b0;
        cnt_d   = LOW_LOAD;
      end
      LOW: begin
        if (cnt_q == 4'd0) begin
          state_d = HIGH;
          wr_n_d  = 1'b1;
          cnt_d   = HIGH_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == 4'd0) begin
          state_d   = IDLE;
          load_next = ~fifo_empty & run_en;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus word changes only here, so it stays put through LOW and HIGH.
    if (load_next) begin
      fifo_pop = 1'b1;
      word_d   = fifo_rdata;
      state_d  = SETUP;
      wr_n_d   = 1'b1;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_STATUS: readdata_d = status;
        ADDR_RST:    readdata_d = rst_rd;
        default:     readdata_d = '0;
      endcase
    end
  end

  // NOTE: non-blocking assignments make every flop sample its _d value from
  // before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_n_q     <= 1'b1;
      word_q     <= '{dc: 1'b1, data: 16'h0000};
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_n_q     <= wr_n_d;
      word_q     <= word_d;
      readdata_q <= readdata_d;
    end
  end

  assign lcd_wr_n       = wr_n_q;
  assign lcd_data_com_n = word_q.dc;
  assign lcd_data       = word_q.data;
  assign avs_readdata   = readdata_q;

endmodule
